// File: rtl/sram_avalon_slave_pkg.sv
// Shared widths, latency and FSM encoding for the SRAM Avalon-MM slave.
package sram_avalon_slave_pkg;

  localparam int SRAM_ADDR_W  = 18;
  localparam int SRAM_DATA_W  = 16;
  localparam int READ_LATENCY = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4
  } state_e;

  function automatic logic is_write_state(input state_e s);
    return (s == WR_SETUP) || (s == WR_PULSE) || (s == WR_HOLD);
  endfunction

endpackage

// File: rtl/sram_avalon_slave_if.sv
// Avalon-MM command/response bundle between the buffer master and the SRAM slave.
interface sram_avalon_slave_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] address;
  logic [1:0]            byteenable;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdatavalid;
  logic                  waitrequest;

  modport master (
    output address, byteenable, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/sram_dq_iobuf.sv
// Registered SRAM DQ driver: data/output-enable flops feeding the pad tristate.
// Latency: drive/release takes effect one cycle after dq_oe_d/dq_load.
// Backpressure: none; follows the controller's registered enable.
module sram_dq_iobuf
  import sram_avalon_slave_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dq_load,
  input  logic [DATA_WIDTH-1:0] dq_wr_dat,
  input  logic                  dq_oe_d,
  output logic [DATA_WIDTH-1:0] dq_rd_dat,
  inout  wire  [DATA_WIDTH-1:0] dq
);

  logic                  dq_oe_q;
  logic [DATA_WIDTH-1:0] dq_out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
    end else begin
      dq_oe_q <= dq_oe_d;
      if (dq_load) dq_out_q <= dq_wr_dat;
    end
  end

  assign dq        = dq_oe_q ? dq_out_q : {DATA_WIDTH{1'bz}};
  assign dq_rd_dat = dq;

endmodule

// File: rtl/sram_avalon_slave.sv
// Avalon-MM slave sequencing a 256Kx16 async SRAM; all pins and responses registered.
// Latency: read data valid 2 cycles after acceptance; writes posted, busy 3 cycles.
// Backpressure: waitrequest high in every non-IDLE state; commands only taken in IDLE.
module sram_avalon_slave
  import sram_avalon_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_W,
  parameter int DATA_WIDTH = SRAM_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  sram_avalon_slave_if.slave     bus,
  inout  wire  [DATA_WIDTH-1:0]  SRAM_DQ,
  output logic [ADDR_WIDTH-1:0]  SRAM_ADDR,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N
);

  state_e state_q, state_nxt;
  logic   accept_rd, accept_wr, accept;

  logic [DATA_WIDTH-1:0] readdata_q;
  logic                  readdatavalid_q;
  logic                  waitrequest_q;
  logic [ADDR_WIDTH-1:0] sram_addr_q;
  logic                  sram_lb_n_q, sram_ub_n_q;
  logic                  sram_ce_n_q, sram_oe_n_q, sram_we_n_q;
  logic [DATA_WIDTH-1:0] dq_rd_dat;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  // Write wins over a simultaneous read; the read is silently dropped.
  always_comb begin
    state_nxt = state_q;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    case (state_q)
      IDLE: begin
        accept_wr = bus.write;
        accept_rd = bus.read & ~bus.write;
        if (accept_wr)      state_nxt = WR_SETUP;
        else if (accept_rd) state_nxt = RD;
      end
      RD:       state_nxt = IDLE;
      WR_SETUP: state_nxt = WR_PULSE;
      WR_PULSE: state_nxt = WR_HOLD;
      WR_HOLD:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign accept = accept_rd | accept_wr;

  // Pins are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      waitrequest_q   <= 1'b0;
      sram_addr_q     <= '0;
      sram_lb_n_q     <= 1'b1;
      sram_ub_n_q     <= 1'b1;
      sram_ce_n_q     <= 1'b1;
      sram_oe_n_q     <= 1'b1;
      sram_we_n_q     <= 1'b1;
    end else begin
      waitrequest_q   <= (state_nxt != IDLE);
      sram_ce_n_q     <= (state_nxt == IDLE);
      sram_oe_n_q     <= (state_nxt != RD);
      sram_we_n_q     <= (state_nxt != WR_PULSE);
      readdatavalid_q <= (state_q == RD);
      if (state_q == RD) readdata_q <= dq_rd_dat;
      if (accept) begin
        sram_addr_q <= bus.address;
        sram_lb_n_q <= ~bus.byteenable[0];
        sram_ub_n_q <= ~bus.byteenable[1];
      end else if (state_nxt == IDLE) begin
        sram_lb_n_q <= 1'b1;
        sram_ub_n_q <= 1'b1;
      end
    end
  end

  sram_dq_iobuf #(.DATA_WIDTH(DATA_WIDTH)) u_dq (
    .clk       (clk),
    .reset     (reset),
    .dq_load   (accept_wr),
    .dq_wr_dat (bus.writedata),
    .dq_oe_d   (is_write_state(state_nxt)),
    .dq_rd_dat (dq_rd_dat),
    .dq        (SRAM_DQ)
  );

  assign bus.readdata      = readdata_q;
  assign bus.readdatavalid = readdatavalid_q;
  assign bus.waitrequest   = waitrequest_q;
  assign SRAM_ADDR         = sram_addr_q;
  assign SRAM_LB_N         = sram_lb_n_q;
  assign SRAM_UB_N         = sram_ub_n_q;
  assign SRAM_CE_N         = sram_ce_n_q;
  assign SRAM_OE_N         = sram_oe_n_q;
  assign SRAM_WE_N         = sram_we_n_q;

endmodule

// File: tb/tb_sram_avalon_slave.sv
// Bench for sram_avalon_slave: async SRAM pin model, word-level reference memory, read-response scoreboard.
module tb_sram_avalon_slave;
  import sram_avalon_slave_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_avalon_slave_if #(.ADDR_WIDTH(18), .DATA_WIDTH(16)) bus ();

  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        lb_n, ub_n, ce_n, oe_n, we_n;

  sram_avalon_slave dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_LB_N (lb_n),
    .SRAM_UB_N (ub_n),
    .SRAM_CE_N (ce_n),
    .SRAM_OE_N (oe_n),
    .SRAM_WE_N (we_n)
  );

  // Pin-level SRAM: drives the bus while selected with OE low, latches enabled bytes while WE is low.
  logic [15:0] mem [0:262143];
  assign sram_dq = (!ce_n && !oe_n) ? mem[sram_addr] : 16'hzzzz;
  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) mem[sram_addr][7:0]  <= sram_dq[7:0];
      if (!ub_n) mem[sram_addr][15:8] <= sram_dq[15:8];
    end
  end

  // Reference: word memory plus queue of expected read responses (due cycle, data, compared bits).
  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic [15:0] mask;
  } exp_t;

  logic [15:0] ref_mem [logic [17:0]];
  exp_t        exp_q [$];
  exp_t        mon_e;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_valid_cyc = -100;
  int prev_valid_cyc = -100;
  logic [15:0] last_rdata = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.readdatavalid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rdv_unexpected: readdatavalid=1 at cycle %0d, required 0", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || ((bus.readdata ^ mon_e.data) & mon_e.mask) != 16'h0) begin
          n_bad++;
          $display("FAIL rd_response: cycle %0d data %h, required cycle %0d data %h mask %h",
                   cyc, bus.readdata, mon_e.cyc, mon_e.data, mon_e.mask);
        end
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
        last_rdata     = bus.readdata;
      end
    end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rdv_missing: no readdatavalid by cycle %0d, required at cycle %0d", cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    n_cmp++;
    if ((!oe_n && !we_n) || (!oe_n && dut.u_dq.dq_oe_q)) begin
      n_bad++;
      $display("FAIL bus_checker: oe_n=%b we_n=%b dq_oe=%b at cycle %0d, required no OE/WE or OE/DQ overlap",
               oe_n, we_n, dut.u_dq.dq_oe_q, cyc);
    end
  end

  function automatic logic [15:0] be_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  // Issues one command in the first free cycle; returns at the negedge after acceptance.
  task automatic issue(input bit rd, input bit wr, input logic [17:0] a,
                       input logic [1:0] be, input logic [15:0] d);
    int guard;
    logic [15:0] m, old;
    guard = 0;
    while (bus.waitrequest !== 1'b0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_timeout: waitrequest=%b after 20 cycles, required 0", bus.waitrequest);
    end
    bus.address    = a;
    bus.byteenable = be;
    bus.writedata  = d;
    bus.read       = rd;
    bus.write      = wr;
    m = be_mask(be);
    if (wr) begin
      old = ref_mem.exists(a) ? ref_mem[a] : 16'h0;
      ref_mem[a] = (old & ~m) | (d & m);
    end else if (rd) begin
      exp_q.push_back('{cyc: cyc + READ_LATENCY, data: (ref_mem.exists(a) ? ref_mem[a] : 16'h0), mask: m});
    end
    @(negedge clk);
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.address    = 18'($urandom);
    bus.writedata  = 16'($urandom);
    bus.byteenable = 2'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.readdatavalid, bus.waitrequest, ce_n, oe_n, we_n, lb_n, ub_n, dut.u_dq.dq_oe_q} !== 8'b0011_1110
        || bus.readdata !== 16'h0 || sram_addr !== 18'h0) begin
      n_bad++;
      $display("FAIL reset_state: rdv,wr,ce,oe,we,lb,ub,dqoe=%b rdata=%h addr=%h, required 00111110 0000 00000",
               {bus.readdatavalid, bus.waitrequest, ce_n, oe_n, we_n, lb_n, ub_n, dut.u_dq.dq_oe_q},
               bus.readdata, sram_addr);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.waitrequest !== 1'b0 || ce_n !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_after_reset: waitrequest=%b ce_n=%b, required 0 1", bus.waitrequest, ce_n);
    end
  endtask

  task automatic test_write_read();
    int we_cnt, we_at;
    issue(1'b0, 1'b1, 18'h00010, 2'b11, 16'h1A2B);
    n_cmp++;
    if ({ce_n, we_n, oe_n, lb_n, ub_n, bus.waitrequest, dut.u_dq.dq_oe_q} !== 7'b0110011
        || sram_addr !== 18'h00010 || sram_dq !== 16'h1A2B) begin
      n_bad++;
      $display("FAIL wr_setup: ce,we,oe,lb,ub,wr,dqoe=%b addr=%h dq=%h, required 0110011 00010 1a2b",
               {ce_n, we_n, oe_n, lb_n, ub_n, bus.waitrequest, dut.u_dq.dq_oe_q}, sram_addr, sram_dq);
    end
    we_cnt = 0;
    we_at  = 0;
    for (int i = 1; i <= 4; i++) begin
      if (we_n === 1'b0) begin
        we_cnt++;
        we_at = i;
      end
      if (i == 3) begin
        n_cmp++;
        if ({ce_n, we_n, bus.waitrequest, dut.u_dq.dq_oe_q} !== 4'b0111) begin
          n_bad++;
          $display("FAIL wr_hold: ce,we,wr,dqoe=%b, required 0111", {ce_n, we_n, bus.waitrequest, dut.u_dq.dq_oe_q});
        end
      end
      if (i < 4) @(negedge clk);
    end
    n_cmp++;
    if (we_cnt != 1 || we_at != 2) begin
      n_bad++;
      $display("FAIL we_pulse: %0d low cycles at N+%0d, required 1 at N+2", we_cnt, we_at);
    end
    n_cmp++;
    if ({bus.waitrequest, ce_n, dut.u_dq.dq_oe_q} !== 3'b010) begin
      n_bad++;
      $display("FAIL wr_done: wr,ce,dqoe=%b, required 010", {bus.waitrequest, ce_n, dut.u_dq.dq_oe_q});
    end
    issue(1'b1, 1'b0, 18'h00010, 2'b11, 16'h0);
    n_cmp++;
    if ({bus.waitrequest, ce_n, oe_n, we_n} !== 4'b1001) begin
      n_bad++;
      $display("FAIL rd_strobes: wr,ce,oe,we=%b, required 1001", {bus.waitrequest, ce_n, oe_n, we_n});
    end
    @(negedge clk);
    n_cmp++;
    if (bus.readdatavalid !== 1'b1 || bus.readdata !== 16'h1A2B || bus.waitrequest !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_data: rdv=%b data=%h wr=%b, required 1 1a2b 0",
               bus.readdatavalid, bus.readdata, bus.waitrequest);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 1'b0, 18'h00000, 2'b11, 16'h0);
    n_cmp++;
    if (bus.waitrequest !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_wait1: waitrequest=%b, required 1", bus.waitrequest);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.waitrequest !== 1'b0 || bus.readdatavalid !== 1'b1 || bus.readdata !== 16'h0001) begin
      n_bad++;
      $display("FAIL b2b_first: wr=%b rdv=%b data=%h, required 0 1 0001",
               bus.waitrequest, bus.readdatavalid, bus.readdata);
    end
    issue(1'b1, 1'b0, 18'h3FFFF, 2'b11, 16'h0);
    @(negedge clk);
    n_cmp++;
    if (bus.readdatavalid !== 1'b1 || bus.readdata !== 16'hFFFE) begin
      n_bad++;
      $display("FAIL b2b_second: rdv=%b data=%h, required 1 fffe", bus.readdatavalid, bus.readdata);
    end
    @(negedge clk);
    n_cmp++;
    if (last_valid_cyc - prev_valid_cyc != 2) begin
      n_bad++;
      $display("FAIL b2b_spacing: valids %0d cycles apart, required 2", last_valid_cyc - prev_valid_cyc);
    end
  endtask

  task automatic test_byte_enable();
    issue(1'b0, 1'b1, 18'h00020, 2'b11, 16'h1234);
    issue(1'b0, 1'b1, 18'h00020, 2'b10, 16'hAB00);
    n_cmp++;
    if ({ub_n, lb_n} !== 2'b01) begin
      n_bad++;
      $display("FAIL be_hi_pins: ub_n,lb_n=%b, required 01", {ub_n, lb_n});
    end
    issue(1'b1, 1'b0, 18'h00020, 2'b11, 16'h0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (last_rdata !== 16'hAB34) begin
      n_bad++;
      $display("FAIL be_hi_merge: read %h, required ab34", last_rdata);
    end
    issue(1'b0, 1'b1, 18'h00020, 2'b00, 16'hFFFF);
    n_cmp++;
    if ({ub_n, lb_n, ce_n} !== 3'b110) begin
      n_bad++;
      $display("FAIL be_none_pins: ub_n,lb_n,ce_n=%b, required 110", {ub_n, lb_n, ce_n});
    end
    issue(1'b1, 1'b0, 18'h00020, 2'b00, 16'h0);
    issue(1'b1, 1'b0, 18'h00020, 2'b11, 16'h0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (last_rdata !== 16'hAB34) begin
      n_bad++;
      $display("FAIL be_none_unchanged: read %h, required ab34", last_rdata);
    end
  endtask

  task automatic test_collision();
    int rdv_cnt;
    issue(1'b1, 1'b1, 18'h00005, 2'b11, 16'h5555);
    rdv_cnt = 0;
    repeat (5) begin
      if (bus.readdatavalid === 1'b1) rdv_cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (rdv_cnt != 0) begin
      n_bad++;
      $display("FAIL collision_no_rdv: %0d strobes, required 0", rdv_cnt);
    end
    issue(1'b1, 1'b0, 18'h00005, 2'b11, 16'h0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (last_rdata !== 16'h5555) begin
      n_bad++;
      $display("FAIL collision_write: read %h, required 5555", last_rdata);
    end
  endtask

  task automatic test_reset_mid_op();
    issue(1'b0, 1'b1, 18'h00077, 2'b11, 16'hBEEF);
    @(negedge clk);
    n_cmp++;
    if (we_n !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_wr_pulse: we_n=%b, required 0", we_n);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({we_n, ce_n, oe_n, dut.u_dq.dq_oe_q, bus.waitrequest, bus.readdatavalid} !== 6'b111000) begin
      n_bad++;
      $display("FAIL rst_mid_write: we,ce,oe,dqoe,wr,rdv=%b, required 111000",
               {we_n, ce_n, oe_n, dut.u_dq.dq_oe_q, bus.waitrequest, bus.readdatavalid});
    end
    reset = 1'b0;
    @(negedge clk);
    issue(1'b1, 1'b0, 18'h00000, 2'b11, 16'h0);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.readdatavalid, oe_n, ce_n} !== 3'b011) begin
      n_bad++;
      $display("FAIL rst_mid_read: rdv,oe,ce=%b, required 011", {bus.readdatavalid, oe_n, ce_n});
    end
    exp_q.delete();
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [17:0] pool [8];
    int op;
    for (int i = 0; i < 8; i++) begin
      pool[i] = 18'h00100 + 18'(i * 37);
      issue(1'b0, 1'b1, pool[i], 2'b11, 16'($urandom));
    end
    for (int k = 0; k < 80; k++) begin
      op = $urandom_range(0, 9);
      issue(op < 5 || op == 9, op >= 5, pool[$urandom_range(0, 7)],
            2'($urandom_range(0, 3)), 16'($urandom));
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.address    = '0;
    bus.byteenable = 2'b00;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.writedata  = '0;
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0;
    mem[0]             = 16'h0001;
    mem[18'h3FFFF]     = 16'hFFFE;
    ref_mem[18'h00000] = 16'h0001;
    ref_mem[18'h3FFFF] = 16'hFFFE;

    test_reset();
    test_write_read();
    test_back_to_back();
    test_byte_enable();
    test_collision();
    test_reset_mid_op();
    test_random();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rd_outstanding: %0d responses never returned, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
